countdown_timer: RTL and testbench

- Loadable down-counter/timer: counts down from a programmed period to zero and signals expiry.
- The count-down counterpart of the up-counting `counter` block. Game logic uses it for per-level timers, respawn delays and move cooldowns.
- Start/abort/pause control with a one-cycle done pulse and an expiry level.
- Sits between game control FSMs and the pixel-clock tick generator, which supplies `en`.

---
 rtl/countdown_timer.sv | 121 ++++++++++++
 tb/tb_countdown_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause/abort control, one-cycle done pulse and expiry level.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the stored period on expiry instead of stopping.
module countdown_timer #(
    parameter int          DATA_WIDTH  = 20,
    parameter int          STEP        = 1,
    parameter int unsigned PERIOD_INIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  expired
);

    localparam logic [DATA_WIDTH-1:0] STEP_W   = DATA_WIDTH'(STEP);
    localparam logic [DATA_WIDTH-1:0] PERIOD_R = DATA_WIDTH'(PERIOD_INIT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] period;
    logic [DATA_WIDTH-1:0] eff_period;

    // A load in the same cycle as start takes effect immediately.
    assign eff_period = load ? load_val : period;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            period  <= PERIOD_R;
            busy    <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                period <= load_val;
            end

            if (abort) begin
                state   <= IDLE;
                count   <= '0;
                busy    <= 1'b0;
                expired <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            if (eff_period == '0) begin
                                state   <= DONE;
                                count   <= '0;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                expired <= 1'b1;
                            end else begin
                                state   <= RUN;
                                count   <= eff_period;
                                busy    <= 1'b1;
                                expired <= 1'b0;
                            end
                        end
                    end

                    RUN: begin
                        if (pause) begin
                            state <= HOLD;
                        end else if (en) begin
                            if (count > STEP_W) begin
                                count <= count - STEP_W;
                            end else begin
                                done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                if (period != '0) begin
                                    count <= period;
                                end else begin
                                    state   <= DONE;
                                    count   <= '0;
                                    busy    <= 1'b0;
                                    expired <= 1'b1;
                                end
`else
                                state   <= DONE;
                                count   <= '0;
                                busy    <= 1'b0;
                                expired <= 1'b1;
`endif
                            end
                        end
                    end

                    HOLD: begin
                        if (!pause) begin
                            state <= RUN;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        count   <= '0;
                        busy    <= 1'b0;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one STEP=1 instance and one STEP=3 instance share stimulus.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [19:0] loadVal;
    logic        start;
    logic        pause;
    logic        abort;

    logic [19:0] countA;
    logic        busyA, doneA, expiredA;
    logic [7:0]  countB;
    logic        busyB, doneB, expiredB;

    int vecCount  = 0;
    int missCount = 0;

    countdown_timer #(.DATA_WIDTH(20), .STEP(1), .PERIOD_INIT(0)) dutA (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(loadVal),
        .start(start), .pause(pause), .abort(abort),
        .count(countA), .busy(busyA), .done(doneA), .expired(expiredA)
    );

    countdown_timer #(.DATA_WIDTH(8), .STEP(3), .PERIOD_INIT(0)) dutB (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(loadVal[7:0]),
        .start(start), .pause(pause), .abort(abort),
        .count(countB), .busy(busyB), .done(doneB), .expired(expiredB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic applyStimulus(input logic iEn, input logic iLoad, input logic [19:0] iVal,
                                 input logic iStart, input logic iPause, input logic iAbort);
        en      = iEn;
        load    = iLoad;
        loadVal = iVal;
        start   = iStart;
        pause   = iPause;
        abort   = iAbort;
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input int expCount, input bit expBusy,
                          input bit expDone, input bit expExpired);
        checkOutput({tag, ".count"},   32'(countA),   32'(expCount));
        checkOutput({tag, ".busy"},    32'(busyA),    32'(expBusy));
        checkOutput({tag, ".done"},    32'(doneA),    32'(expDone));
        checkOutput({tag, ".expired"}, 32'(expiredA), 32'(expExpired));
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; load = 1'b0; loadVal = '0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        #2 rst = 1'b0;
        #5;
        checkA("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: period 5, STEP 1
        applyStimulus(1, 1, 20'd5, 1, 0, 0);
        checkA("t1_start", 5, 1, 0, 0);
        for (int k = 4; k >= 1; k--) begin
            applyStimulus(1, 0, 20'd0, 0, 0, 0);
            checkA($sformatf("t1_cnt%0d", k), k, 1, 0, 0);
        end
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkA("t1_expire", AUTO ? 5 : 0, AUTO, 1, !AUTO);
        applyStimulus(0, 0, 20'd0, 0, 0, 0);
        checkA("t1_after", AUTO ? 5 : 0, AUTO, 0, !AUTO);

        // Test 2: STEP 3 instance, period 7
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 1, 20'd7, 1, 0, 0);
        checkOutput("t2_start", 32'(countB), 32'd7);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkOutput("t2_cnt4", 32'(countB), 32'd4);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkOutput("t2_cnt1", 32'(countB), 32'd1);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkOutput("t2_sat", 32'(countB), AUTO ? 32'd7 : 32'd0);
        checkOutput("t2_done", 32'(doneB), 32'd1);
        checkOutput("t2_expired", 32'(expiredB), AUTO ? 32'd0 : 32'd1);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkOutput("t2_nowrap", 32'(countB), AUTO ? 32'd4 : 32'd0);
        checkOutput("t2_done_once", 32'(doneB), 32'd0);

        // Test 3: period 10, pause at 6 for 4 cycles
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 1, 20'd10, 1, 0, 0);
        checkA("t3_start", 10, 1, 0, 0);
        for (int k = 9; k >= 6; k--) begin
            applyStimulus(1, 0, 20'd0, 0, 0, 0);
        end
        checkA("t3_at6", 6, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 20'd0, 0, 1, 0);
            checkA($sformatf("t3_hold%0d", k), 6, 1, 0, 0);
        end
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkA("t3_unpause", 6, 1, 0, 0);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkA("t3_cnt5", 5, 1, 0, 0);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkA("t3_cnt4", 4, 1, 0, 0);

        // Test 4: abort beats start at count 3
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 1, 20'd8, 1, 0, 0);
        checkA("t4_start", 8, 1, 0, 0);
        for (int k = 7; k >= 3; k--) begin
            applyStimulus(1, 0, 20'd0, 0, 0, 0);
        end
        checkA("t4_at3", 3, 1, 0, 0);
        applyStimulus(1, 0, 20'd0, 1, 0, 1);
        checkA("t4_abort", 0, 0, 0, 0);
        applyStimulus(1, 0, 20'd0, 1, 0, 0);
        checkA("t4_restart", 8, 1, 0, 0);

        // Test 5: zero period, then load during run
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 1, 20'd0, 1, 0, 0);
        checkA("t5_zero", 0, 0, 1, 1);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkA("t5_zero_hold", 0, 0, 0, 1);
        applyStimulus(1, 1, 20'd6, 1, 0, 0);
        checkA("t5_start6", 6, 1, 0, 0);
        applyStimulus(1, 1, 20'd4, 0, 0, 0);
        checkA("t5_load_mid", 5, 1, 0, 0);
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 0, 20'd0, 1, 0, 0);
        checkA("t5_newperiod", 4, 1, 0, 0);

        // Test 6: asynchronous reset mid-run clears period too
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 1, 20'd9, 1, 0, 0);
        applyStimulus(1, 0, 20'd0, 0, 0, 0);
        checkA("t6_run", 8, 1, 0, 0);
        #3 rst = 1'b0;
        #1;
        checkA("t6_async", 0, 0, 0, 0);
        #2 rst = 1'b1;
        applyStimulus(1, 0, 20'd0, 1, 0, 0);
        checkA("t6_period_cleared", 0, 0, 1, 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto-reload: period 3 pulses done every 3 enabled cycles
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        applyStimulus(1, 1, 20'd3, 1, 0, 0);
        checkA("ar_start", 3, 1, 0, 0);
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(1, 0, 20'd0, 0, 0, 0);
            checkA($sformatf("ar_cnt2_%0d", rep), 2, 1, 0, 0);
            applyStimulus(1, 0, 20'd0, 0, 0, 0);
            checkA($sformatf("ar_cnt1_%0d", rep), 1, 1, 0, 0);
            applyStimulus(1, 0, 20'd0, 0, 0, 0);
            checkA($sformatf("ar_reload_%0d", rep), 3, 1, 1, 0);
        end
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        checkA("ar_abort", 0, 0, 0, 0);
`else
        // One-shot: DONE persists until start or abort
        applyStimulus(1, 0, 20'd0, 0, 1, 0);
        checkA("os_stay_done", 0, 0, 0, 1);
        applyStimulus(0, 0, 20'd0, 0, 0, 1);
        checkA("os_abort", 0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
